// File: rtl/bram_dp_pipe.sv
// -----------------------------------------------------------------------------
// bram_dp_pipe
//   True dual-port block RAM with per-byte write enables and a registered read
//   pipeline of RD_LAT stages (1..3) carrying a valid flag per port. Port
//   behaviour on a same-port read/write is read-first (WR_MODE=0) or
//   write-first (WR_MODE=1). Both ports share one clock domain.
//
// Ports
//   CLK            clock, all state changes on the rising edge
//   RST            synchronous active-high reset (pipeline only, not memory)
//   EN_A / EN_B    access enable; every enabled access also reads the word
//   WE_A / WE_B    byte-lane write enables (NB bits), ignored when EN is low
//   A_A  / A_B     word address (ADDR_W bits); addresses >= DEPTH are inert
//   DI_A / DI_B    write data
//   DO_A / DO_B    read data, forced to 0 whenever the matching VLD is low
//   VLD_A / VLD_B  high when DO holds a read issued RD_LAT-1 edges earlier
// -----------------------------------------------------------------------------
module bram_dp_pipe #(
    parameter  int DATA_W  = 32,
    parameter  int DEPTH   = 256,
    parameter  int RD_LAT  = 1,
    parameter  int WR_MODE = 0,
    localparam int NB      = DATA_W / 8,
    localparam int ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN_A,
    input  logic [NB-1:0]     WE_A,
    input  logic [ADDR_W-1:0] A_A,
    input  logic [DATA_W-1:0] DI_A,
    output logic [DATA_W-1:0] DO_A,
    output logic              VLD_A,
    input  logic              EN_B,
    input  logic [NB-1:0]     WE_B,
    input  logic [ADDR_W-1:0] A_B,
    input  logic [DATA_W-1:0] DI_B,
    output logic [DATA_W-1:0] DO_B,
    output logic              VLD_B
);

    generate
        if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_lat
            $error("bram_dp_pipe: RD_LAT must be in 1..3");
        end
        if ((DATA_W % 8) != 0) begin : g_bad_width
            $error("bram_dp_pipe: DATA_W must be a multiple of 8");
        end
    endgenerate

    // One extra bit so DEPTH itself is representable (DEPTH = 2**ADDR_W case).
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    logic [DATA_W-1:0] dat_a_q [0:RD_LAT-1];
    logic [DATA_W-1:0] dat_b_q [0:RD_LAT-1];
    logic              vld_a_q [0:RD_LAT-1];
    logic              vld_b_q [0:RD_LAT-1];

    logic              in_a, in_b;
    logic [DATA_W-1:0] rd_a_d, rd_b_d;

    // Out-of-range addresses never touch the array: no aliasing on wrap.
    assign in_a = ({1'b0, A_A} < DEPTH_C);
    assign in_b = ({1'b0, A_B} < DEPTH_C);

    // Stage-1 capture value. The array is read before this edge's writes land,
    // so the other port always sees the pre-write word; write-first only
    // overlays this port's own enabled lanes.
    always_comb begin
        rd_a_d = '0;
        if (EN_A && in_a) begin
            rd_a_d = mem_q[A_A];
            if (WR_MODE != 0) begin
                for (int i = 0; i < NB; i++) begin
                    if (WE_A[i]) rd_a_d[8*i +: 8] = DI_A[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_b_d = '0;
        if (EN_B && in_b) begin
            rd_b_d = mem_q[A_B];
            if (WR_MODE != 0) begin
                for (int i = 0; i < NB; i++) begin
                    if (WE_B[i]) rd_b_d[8*i +: 8] = DI_B[8*i +: 8];
                end
            end
        end
    end

    // Memory array: no reset so it maps onto block RAM. Port B is applied
    // first so that port A's non-blocking update wins on shared lanes.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (EN_B && in_b) begin
                for (int i = 0; i < NB; i++) begin
                    if (WE_B[i]) mem_q[A_B][8*i +: 8] <= DI_B[8*i +: 8];
                end
            end
            if (EN_A && in_a) begin
                for (int i = 0; i < NB; i++) begin
                    if (WE_A[i]) mem_q[A_A][8*i +: 8] <= DI_A[8*i +: 8];
                end
            end
        end
    end

    // Read pipeline: stage 0 captures, later stages shift. A bubble carries
    // zero data so DO stays 0 whenever VLD is low.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < RD_LAT; i++) begin
                dat_a_q[i] <= '0;
                dat_b_q[i] <= '0;
                vld_a_q[i] <= 1'b0;
                vld_b_q[i] <= 1'b0;
            end
        end else begin
            dat_a_q[0] <= rd_a_d;
            dat_b_q[0] <= rd_b_d;
            vld_a_q[0] <= EN_A;
            vld_b_q[0] <= EN_B;
            for (int i = 1; i < RD_LAT; i++) begin
                dat_a_q[i] <= dat_a_q[i-1];
                dat_b_q[i] <= dat_b_q[i-1];
                vld_a_q[i] <= vld_a_q[i-1];
                vld_b_q[i] <= vld_b_q[i-1];
            end
        end
    end

    assign DO_A  = dat_a_q[RD_LAT-1];
    assign DO_B  = dat_b_q[RD_LAT-1];
    assign VLD_A = vld_a_q[RD_LAT-1];
    assign VLD_B = vld_b_q[RD_LAT-1];

endmodule

// File: tb/tb_bram_dp_pipe.sv
// Bench for bram_dp_pipe: three instances with different RD_LAT / WR_MODE /
// DEPTH share one stimulus stream. A word-level memory model predicts each
// read at issue time and queues it with its due cycle; a monitor on the
// falling edge pops and compares whenever VLD is presented.
module tb_bram_dp_pipe;

    localparam int NI = 3;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int mode_of(input int k);
        return (k == 1) ? 1 : 0;
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 256 : 200;
    endfunction

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] due;
        logic        dc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_a, en_b;
    logic [3:0]  we_a, we_b;
    logic [7:0]  a_a, a_b;
    logic [31:0] di_a, di_b;

    logic [31:0] do_w  [0:2*NI-1];
    logic        vld_w [0:2*NI-1];

    exp_t        sb [0:2*NI-1][$];
    logic [31:0] mdl   [0:NI-1][0:255];
    logic        known [0:NI-1][0:255];

    int cyc = 0;
    logic rst_seen = 1'b0;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bram_dp_pipe #(.DATA_W(32), .DEPTH(256), .RD_LAT(1), .WR_MODE(0)) u0 (
        .CLK(clk), .RST(rst),
        .EN_A(en_a), .WE_A(we_a), .A_A(a_a), .DI_A(di_a), .DO_A(do_w[0]), .VLD_A(vld_w[0]),
        .EN_B(en_b), .WE_B(we_b), .A_B(a_b), .DI_B(di_b), .DO_B(do_w[1]), .VLD_B(vld_w[1]));

    bram_dp_pipe #(.DATA_W(32), .DEPTH(200), .RD_LAT(2), .WR_MODE(1)) u1 (
        .CLK(clk), .RST(rst),
        .EN_A(en_a), .WE_A(we_a), .A_A(a_a), .DI_A(di_a), .DO_A(do_w[2]), .VLD_A(vld_w[2]),
        .EN_B(en_b), .WE_B(we_b), .A_B(a_b), .DI_B(di_b), .DO_B(do_w[3]), .VLD_B(vld_w[3]));

    bram_dp_pipe #(.DATA_W(32), .DEPTH(200), .RD_LAT(3), .WR_MODE(0)) u2 (
        .CLK(clk), .RST(rst),
        .EN_A(en_a), .WE_A(we_a), .A_A(a_a), .DI_A(di_a), .DO_A(do_w[4]), .VLD_A(vld_w[4]),
        .EN_B(en_b), .WE_B(we_b), .A_B(a_b), .DI_B(di_b), .DO_B(do_w[5]), .VLD_B(vld_w[5]));

    // Reference model: predict reads from the pre-edge memory image, then
    // apply writes with B first so A takes precedence on shared lanes.
    always @(posedge clk) begin
        cyc++;
        rst_seen = rst;
        if (rst) begin
            for (int j = 0; j < 2*NI; j++) sb[j].delete();
        end else begin
            for (int k = 0; k < NI; k++) begin
                for (int p = 0; p < 2; p++) begin
                    logic        en;
                    logic [3:0]  we;
                    logic [7:0]  ad;
                    logic [31:0] di, w;
                    exp_t        e;
                    en = p ? en_b : en_a;
                    we = p ? we_b : we_a;
                    ad = p ? a_b  : a_a;
                    di = p ? di_b : di_a;
                    if (en) begin
                        e.due = cyc + lat_of(k) - 1;
                        if (int'(ad) >= depth_of(k)) begin
                            e.d  = 32'h0;
                            e.dc = 1'b0;
                        end else begin
                            w = mdl[k][ad];
                            if (mode_of(k) == 1) begin
                                for (int i = 0; i < 4; i++)
                                    if (we[i]) w[8*i +: 8] = di[8*i +: 8];
                            end
                            e.d  = w;
                            e.dc = !known[k][ad];
                        end
                        sb[k*2+p].push_back(e);
                    end
                end
                for (int p = 1; p >= 0; p--) begin
                    logic        en;
                    logic [3:0]  we;
                    logic [7:0]  ad;
                    logic [31:0] di;
                    en = p ? en_b : en_a;
                    we = p ? we_b : we_a;
                    ad = p ? a_b  : a_a;
                    di = p ? di_b : di_a;
                    if (en && int'(ad) < depth_of(k)) begin
                        for (int i = 0; i < 4; i++)
                            if (we[i]) mdl[k][ad][8*i +: 8] = di[8*i +: 8];
                        if (we == 4'hF) known[k][ad] = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: compare whatever the DUT presents, away from the rising edge.
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int j = 0; j < 2*NI; j++) begin
                if (rst_seen) begin
                    n_cmp++;
                    if (vld_w[j] !== 1'b0 || do_w[j] !== 32'h0) begin
                        n_bad++;
                        $display("FAIL reset_out inst%0d port%0d cyc %0d: vld=%b do=%h, required vld=0 do=0",
                                 j/2, j%2, cyc, vld_w[j], do_w[j]);
                    end
                end else if (vld_w[j] === 1'b1) begin
                    n_cmp++;
                    if (sb[j].size() == 0) begin
                        n_bad++;
                        $display("FAIL spurious_vld inst%0d port%0d cyc %0d: do=%h with no read in flight",
                                 j/2, j%2, cyc, do_w[j]);
                    end else begin
                        exp_t e;
                        e = sb[j].pop_front();
                        if (int'(e.due) != cyc || (!e.dc && do_w[j] !== e.d)) begin
                            n_bad++;
                            $display("FAIL read_data inst%0d port%0d: got %h at cyc %0d, required %h at cyc %0d",
                                     j/2, j%2, do_w[j], cyc, e.d, e.due);
                        end
                    end
                end else begin
                    n_cmp++;
                    if (vld_w[j] !== 1'b0 || do_w[j] !== 32'h0) begin
                        n_bad++;
                        $display("FAIL idle_out inst%0d port%0d cyc %0d: vld=%b do=%h, required vld=0 do=0",
                                 j/2, j%2, cyc, vld_w[j], do_w[j]);
                    end
                    if (sb[j].size() > 0 && int'(sb[j][0].due) <= cyc) begin
                        exp_t e;
                        e = sb[j].pop_front();
                        n_cmp++;
                        n_bad++;
                        $display("FAIL missing_vld inst%0d port%0d: no VLD at cyc %0d, required data %h",
                                 j/2, j%2, cyc, e.d);
                    end
                end
            end
        end
    end

    task automatic drv(input logic ea, input logic [3:0] wa, input logic [7:0] aa, input logic [31:0] da,
                       input logic eb, input logic [3:0] wb, input logic [7:0] ab, input logic [31:0] db);
        en_a = ea; we_a = wa; a_a = aa; di_a = da;
        en_b = eb; we_b = wb; a_b = ab; di_b = db;
        @(negedge clk);
    endtask

    task automatic idle();
        drv(1'b0, 4'h0, 8'h0, 32'h0, 1'b0, 4'h0, 8'h0, 32'h0);
    endtask

    initial begin
        for (int k = 0; k < NI; k++)
            for (int a = 0; a < 256; a++) begin
                mdl[k][a]   = 32'h0;
                known[k][a] = 1'b0;
            end
        rst = 1'b1;
        en_a = 1'b0; we_a = 4'h0; a_a = 8'h0; di_a = 32'h0;
        en_b = 1'b0; we_b = 4'h0; a_b = 8'h0; di_b = 32'h0;
        @(negedge clk);
        idle();
        idle();
        rst = 1'b0;

        // Fill every word so later reads have defined expectations.
        for (int i = 0; i < 128; i++)
            drv(1'b1, 4'hF, 8'(2*i), $urandom, 1'b1, 4'hF, 8'(2*i+1), $urandom);

        // Byte lanes at address 5.
        drv(1'b1, 4'hF, 8'd5, 32'hAABBCCDD, 1'b0, 4'h0, 8'd0, 32'h0);
        drv(1'b1, 4'b0101, 8'd5, 32'h11223344, 1'b0, 4'h0, 8'd0, 32'h0);
        drv(1'b1, 4'h0, 8'd5, 32'h0, 1'b1, 4'h0, 8'd5, 32'h0);
        idle();

        // Back-to-back streaming reads on both ports.
        for (int i = 0; i < 8; i++)
            drv(1'b1, 4'h0, 8'(i), 32'h0, 1'b1, 4'h0, 8'(7-i), 32'h0);
        idle();
        idle();
        idle();

        // Collision at address 9: A writes, B reads in the same cycle.
        drv(1'b1, 4'hF, 8'd9, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0);
        drv(1'b1, 4'hF, 8'd9, 32'h12345678, 1'b1, 4'h0, 8'd9, 32'h0);
        drv(1'b1, 4'h0, 8'd9, 32'h0, 1'b0, 4'h0, 8'd0, 32'h0);

        // Dual write to address 3.
        drv(1'b1, 4'hF, 8'd3, 32'h01020304, 1'b0, 4'h0, 8'd0, 32'h0);
        drv(1'b1, 4'b0011, 8'd3, 32'hFFFFFFFF, 1'b1, 4'b0110, 8'd3, 32'h0);
        drv(1'b1, 4'h0, 8'd3, 32'h0, 1'b1, 4'h0, 8'd3, 32'h0);

        // Out-of-range address on the DEPTH=200 instances.
        drv(1'b1, 4'hF, 8'd50, 32'h00005050, 1'b0, 4'h0, 8'd0, 32'h0);
        drv(1'b1, 4'hF, 8'd250, 32'h0000DEAD, 1'b0, 4'h0, 8'd0, 32'h0);
        drv(1'b1, 4'h0, 8'd250, 32'h0, 1'b1, 4'h0, 8'd50, 32'h0);
        idle();

        // Reset held three cycles in the middle of a read burst.
        for (int i = 0; i < 4; i++)
            drv(1'b1, 4'h0, 8'(i), 32'h0, 1'b1, 4'h0, 8'(i+4), 32'h0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++)
            drv(1'b1, 4'hF, 8'd5, 32'hBAD0BAD0, 1'b1, 4'hF, 8'd6, 32'hBAD1BAD1);
        rst = 1'b0;
        drv(1'b1, 4'h0, 8'd5, 32'h0, 1'b1, 4'h0, 8'd6, 32'h0);
        idle();
        idle();
        idle();

        // Random traffic, biased towards a small address window for collisions.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] ra, rb;
            ra = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            rb = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
            drv(1'($urandom_range(0, 3) != 0), 4'($urandom), ra, $urandom,
                1'($urandom_range(0, 3) != 0), 4'($urandom), rb, $urandom);
        end

        for (int i = 0; i < 6; i++) idle();

        for (int j = 0; j < 2*NI; j++) begin
            n_cmp++;
            if (sb[j].size() != 0) begin
                n_bad++;
                $display("FAIL drain inst%0d port%0d: %0d reads never presented, required 0",
                         j/2, j%2, sb[j].size());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
